// File: rtl/fetch_pkg.sv
// Shared constants and the fetch-queue entry type for the dual-issue front end.
package fetch_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned INST_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    localparam fetch_entry_t NOP_ENTRY = '{inst: NOP_INST, pc: '0};

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction FIFO: up to two pushes and two pops per cycle, synchronous flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [1:0]               push_cnt,
    input  fetch_entry_t             push_1,
    input  fetch_entry_t             push_2,
    input  logic [1:0]               pop_cnt,
    output fetch_entry_t             head_1,
    output fetch_entry_t             head_2,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fetch_entry_t    mem_q [QDEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q + PtrW'(pop_cnt);
        tail_d  = tail_q + PtrW'(push_cnt);
        count_d = count_q + CntW'(push_cnt) - CntW'(pop_cnt);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: slots are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_cnt != 2'd0) mem_q[tail_q] <= push_1;
            if (push_cnt == 2'd2) mem_q[tail_q + PtrW'(1)] <= push_2;
        end
    end

    assign head_1 = (count_q != '0)       ? mem_q[head_q]              : NOP_ENTRY;
    assign head_2 = (count_q > CntW'(1))  ? mem_q[head_q + PtrW'(1)]   : NOP_ENTRY;
    assign count  = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch: PC, one in-flight read pair, and a fetch queue feeding decode.
// Optional FETCH_BYPASS_EN forwards returning data straight to decode when the queue is empty.
module fetch_unit #(
    parameter int unsigned                  QDEPTH   = 4,
    parameter logic [fetch_pkg::ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [fetch_pkg::ADDR_W-1:0]   im_addr_1,
    output logic [fetch_pkg::ADDR_W-1:0]   im_addr_2,
    input  logic [fetch_pkg::INST_W-1:0]   im_data_1,
    input  logic [fetch_pkg::INST_W-1:0]   im_data_2,
    input  logic                           redirect_valid,
    input  logic [fetch_pkg::ADDR_W-1:0]   redirect_pc,
    output logic                           dec_valid_1,
    output logic                           dec_valid_2,
    output logic [fetch_pkg::INST_W-1:0]   dec_inst_1,
    output logic [fetch_pkg::INST_W-1:0]   dec_inst_2,
    output logic [fetch_pkg::ADDR_W-1:0]   dec_pc_1,
    output logic [fetch_pkg::ADDR_W-1:0]   dec_pc_2,
    input  logic [1:0]                     dec_take
);

    import fetch_pkg::*;

    localparam int unsigned CntW = $clog2(QDEPTH) + 1;
    localparam int unsigned OccW = CntW + 1;

    logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              issue;
    logic [OccW-1:0]   occ_next;
    logic [CntW-1:0]   q_count;
    logic [1:0]        push_cnt, pop_cnt;
    fetch_entry_t      q_head_1, q_head_2, in_1, in_2, push_1, push_2, slot_1, slot_2;

    assign im_addr_1 = pc_q;
    assign im_addr_2 = pc_q + ADDR_W'(2);

    assign in_1 = '{inst: im_data_1, pc: req_pc_q};
    assign in_2 = '{inst: im_data_2, pc: req_pc_q + ADDR_W'(2)};

    // Occupancy after this edge plus a new pair must fit; dec_take added on the right to
    // keep the comparison unsigned-safe.
    assign occ_next = OccW'(q_count) + (inflight_q ? OccW'(4) : OccW'(2));
    assign issue    = !redirect_valid && (occ_next <= OccW'(QDEPTH) + OccW'(dec_take));

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
        end else if (issue) begin
            pc_d       = pc_q + ADDR_W'(4);
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass = inflight_q && (q_count == '0);
`endif

    always_comb begin
        push_1      = in_1;
        push_2      = in_2;
        push_cnt    = inflight_q ? 2'd2 : 2'd0;
        pop_cnt     = dec_take;
        slot_1      = q_head_1;
        slot_2      = q_head_2;
        dec_valid_1 = (q_count != '0);
        dec_valid_2 = (q_count > CntW'(1));
`ifdef FETCH_BYPASS_EN
        if (bypass) begin
            slot_1      = in_1;
            slot_2      = in_2;
            dec_valid_1 = 1'b1;
            dec_valid_2 = 1'b1;
            pop_cnt     = 2'd0;
            push_cnt    = 2'd2 - dec_take;
            if (dec_take == 2'd1) push_1 = in_2;
        end
`endif
        if (redirect_valid) begin
            push_cnt = 2'd0;
            pop_cnt  = 2'd0;
        end
    end

    assign dec_inst_1 = slot_1.inst;
    assign dec_inst_2 = slot_2.inst;
    assign dec_pc_1   = slot_1.pc;
    assign dec_pc_2   = slot_2.pc;

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_cnt (push_cnt),
        .push_1   (push_1),
        .push_2   (push_2),
        .pop_cnt  (pop_cnt),
        .head_1   (q_head_1),
        .head_2   (q_head_2),
        .count    (q_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected in-order PC stream vs. decode slots.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int ExpLat = 1;
`else
    localparam int ExpLat = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] im_addr_1, im_addr_2, im_data_1, im_data_2;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dec_valid_1, dec_valid_2;
    logic [15:0] dec_inst_1, dec_inst_2, dec_pc_1, dec_pc_2;
    logic [1:0]  dec_take;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:32767];
    logic [15:0] exp_q [$];
    logic [15:0] exp_next;
    logic [15:0] ep;

    logic [1:0]  take_fixed = 2'd2;
    logic        take_rand  = 1'b0;
    int          drv_nv, drv_t;

    always #5 clk = ~clk;

    fetch_unit #(.QDEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .im_addr_1      (im_addr_1),
        .im_addr_2      (im_addr_2),
        .im_data_1      (im_data_1),
        .im_data_2      (im_data_2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid_1    (dec_valid_1),
        .dec_valid_2    (dec_valid_2),
        .dec_inst_1     (dec_inst_1),
        .dec_inst_2     (dec_inst_2),
        .dec_pc_1       (dec_pc_1),
        .dec_pc_2       (dec_pc_2),
        .dec_take       (dec_take)
    );

    // Registered-read instruction memory.
    always @(posedge clk) begin
        im_data_1 <= mem[im_addr_1[15:1]];
        im_data_2 <= mem[im_addr_2[15:1]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 16'd2;
        end
    endtask

    task automatic restart_stream(input logic [15:0] pc);
        exp_q.delete();
        exp_next = {pc[15:1], 1'b0};
        refill();
    endtask

    // Decode consumer: never takes more than is presented.
    always @(posedge clk) begin
        #1;
        drv_nv = dec_valid_2 ? 2 : (dec_valid_1 ? 1 : 0);
        if (take_rand) drv_t = int'($urandom_range(0, drv_nv));
        else drv_t = (int'(take_fixed) > drv_nv) ? drv_nv : int'(take_fixed);
        dec_take = 2'(drv_t);
    end

    // Monitor: compare visible slots to the expected stream, then retire what decode took.
    always @(negedge clk) begin
        if (reset) begin
            check("reset_valid1", dec_valid_1, 0);
            check("reset_valid2", dec_valid_2, 0);
            check("reset_inst1", dec_inst_1, 0);
            check("reset_pc1", dec_pc_1, 0);
            restart_stream(16'h0000);
        end else begin
            if (!dec_valid_1) check("valid2_without_valid1", dec_valid_2, 0);
            if (dec_valid_1) begin
                ep = exp_q[0];
                check("slot1_pc", dec_pc_1, ep);
                check("slot1_inst", dec_inst_1, mem[ep[15:1]]);
            end
            if (dec_valid_2) begin
                ep = exp_q[1];
                check("slot2_pc", dec_pc_2, ep);
                check("slot2_inst", dec_inst_2, mem[ep[15:1]]);
            end
            if (redirect_valid) begin
                restart_stream(redirect_pc);
            end else begin
                for (int i = 0; i < int'(dec_take); i++) void'(exp_q.pop_front());
                refill();
            end
        end
    end

    task automatic wait_first_valid(input string name, input logic [15:0] pc);
        int edges;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!dec_valid_1 && edges < 10);
        check({name, "_latency"}, edges, ExpLat);
        check({name, "_first_pc"}, dec_pc_1, pc);
        check({name, "_first_inst"}, dec_inst_1, mem[pc[15:1]]);
    endtask

    task automatic do_reset(input logic [1:0] take);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid1", dec_valid_1, 0);
        check("async_reset_valid2", dec_valid_2, 0);
        take_fixed = take;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        check("redirect_addr1", im_addr_1, {pc[15:1], 1'b0});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        dec_take       = 2'd0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1898;
        mem[1] = 16'h2A98;
        mem[2] = 16'h0C44;
        mem[3] = 16'h4F80;

        // Reset release, full-rate consumption.
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        wait_first_valid("release", 16'h0000);
        check("release_inst2", dec_inst_2, 16'h2A98);
        @(posedge clk);
        #1;
        check("second_pair_pc1", dec_pc_1, 16'h0004);
        check("second_pair_inst2", dec_inst_2, 16'h4F80);
        repeat (20) begin
            check("no_bubble", dec_valid_2, 1);
            @(posedge clk);
            #1;
        end

        // Stall with a full queue, then drain.
        do_reset(2'd0);
        repeat (8) @(posedge clk);
        #1;
        check("stall_addr1", im_addr_1, 16'h0008);
        check("stall_valid2", dec_valid_2, 1);
        take_fixed = 2'd2;
        repeat (10) @(posedge clk);

        // Single-instruction consumption.
        take_fixed = 2'd1;
        repeat (20) @(posedge clk);

        // Redirect to an odd target with a read in flight.
        do_reset(2'd0);
        repeat (2) @(posedge clk);
        redirect_to(16'h0005);
        take_fixed = 2'd2;
        wait_first_valid("redirect_odd", 16'h0004);

        // Wrap-around through the top of the address space.
        redirect_to(16'hFFFC);
        check("wrap_addr2", im_addr_2, 16'hFFFE);
        wait_first_valid("redirect_wrap", 16'hFFFC);
        check("wrap_pc2", dec_pc_2, 16'hFFFE);
        @(posedge clk);
        #1;
        check("wrap_next_pc1", dec_pc_1, 16'h0000);
        check("wrap_next_pc2", dec_pc_2, 16'h0002);

        // Random consumption and random redirects.
        take_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 16'($urandom);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        repeat (10) @(posedge clk);

        // Reset during a stall with a full queue.
        take_rand = 1'b0;
        take_fixed = 2'd0;
        repeat (8) @(posedge clk);
        do_reset(2'd2);
        wait_first_valid("reset_restart", 16'h0000);
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Dual-issue front end that drives the two address ports of the instruction memory and consumes its two 16-bit instruction outputs. The memory has a registered read, so its data arrives one cycle after the address. The block keeps the PC, tracks the one in-flight read pair, and buffers returned instructions in a small fetch queue. It presents up to two in-order instructions per cycle to decode and supports PC redirect (branch or flush) from the back end.

Parameters:
QDEPTH, 4, fetch-queue capacity in instructions; power of 2, at least 4
RESET_PC, 16'h0000, PC loaded on reset
ADDR_W, 16, address and PC width
INST_W, 16, instruction width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
im_addr_1  out  ADDR_W  byte address of the first instruction of the pair (= pc)
im_addr_2  out  ADDR_W  byte address of the second instruction (= pc+2, mod 2^16)
im_data_1  in  INST_W  memory output for im_addr_1, valid the cycle after the address
im_data_2  in  INST_W  memory output for im_addr_2
redirect_valid  in  1  load a new PC and squash all fetched state
redirect_pc  in  ADDR_W  redirect target; bit 0 is ignored (forced to 0)
dec_valid_1  out  1  slot 1 holds a valid instruction (oldest)
dec_valid_2  out  1  slot 2 holds a valid instruction; never set without dec_valid_1
dec_inst_1  out  INST_W  oldest queued instruction
dec_inst_2  out  INST_W  second-oldest queued instruction
dec_pc_1  out  ADDR_W  PC of dec_inst_1
dec_pc_2  out  ADDR_W  PC of dec_inst_2
dec_take  in  2  instructions consumed by decode this cycle (0..2); must not exceed the valid count

Behaviour:
- im_addr_1/2 are combinational from the pc register.
- Reset: pc=RESET_PC, inflight=0, queue empty, dec_valid_1/2=0, dec_inst_*=0 (NOP), dec_pc_*=0.
- issue = !redirect_valid && (count - dec_take + 2*inflight + 2 <= QDEPTH).
- At the rising edge, if issue: pc <= pc+4 (wraps at 2^16), inflight <= 1, req_pc <= pc. Otherwise inflight <= 0 and pc holds.
- Cycle after issue: im_data_1/2 are pushed at the next edge with PCs req_pc and req_pc+2. Push and pop happen in the same edge.
- Steady state with dec_take=2 every cycle sustains 2 instructions per cycle.
- Queue output order: dec slot 1 = head, slot 2 = head+1. dec_valid_* reflect the registered count (no combinational path from dec_take).
- dec_take=1 pops only the head; the second instruction moves to slot 1 next cycle.
- Queue never overflows; count stays at or below QDEPTH. A full queue with dec_take=0 stalls pc.
- Redirect sampled at an edge:
  - pc <= {redirect_pc[15:1],0}, inflight <= 0, queue flushed, dec_take ignored.
  - Returning data for the squashed request is discarded.
- Redirect latency: redirect at edge T -> new addresses in cycle T+1 -> data in cycle T+2 -> dec_valid_1 in cycle T+3.
- Redirect and issue in the same cycle: redirect wins.
- Reset asserted mid-operation: immediate asynchronous clear to reset values; in-flight data is discarded.
- Wrap-around: pc 16'hFFFC gives addresses FFFC/FFFE, then 0000/0002. Queue pointers wrap modulo QDEPTH.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty and valid in-flight data arrives, im_data_1/2 and their PCs drive dec_* in the same cycle; entries not taken are enqueued. Redirect-to-decode latency drops to 2 cycles (dec_valid_1 in cycle T+2).
- Undefined: all instructions pass through the queue; latency is as specified above.

Decomposition:
- Package fetch_pkg holds ADDR_W, INST_W, RESET_PC, NOP_INST=16'h0000, and the fetch-entry struct {inst, pc}.
- One sub-module: fetch_queue, a circular FIFO with 2-push/2-pop, occupancy count, and synchronous flush.
- fetch_unit holds the PC, in-flight tracking, and issue logic.

Test Plan:
- Reset release with dec_take=2 every cycle, memory preloaded with 0x1898, 0x2A98, 0x0C44, 0x4F80 -> cycle 3 dec = 0x1898/0x2A98 (pc 0/2), cycle 4 dec = 0x0C44/0x4F80 (pc 4/6), no bubbles thereafter.
- dec_take=0 from reset -> queue reaches 4, im_addr_1 holds at 0x0008, count never exceeds 4; then dec_take=2 -> pc 0/2 then 4/6 in order.
- Alternating dec_take=1 -> dec_pc_1 sequence 0, 2, 4, 6 with no skipped or duplicated instruction.
- Redirect to 0x0005 while the queue is full and a read is in flight -> queue flushed, im_addr_1=0x0004 next cycle, first dec_pc_1=0x0004 (0x0C44) at T+3; the stale pair never appears.
- Redirect to 0xFFFC -> dec pcs FFFC/FFFE, then 0000/0002.
- Assert reset during a stall with a full queue -> dec_valid_1/2=0 immediately (asynchronous); after release, fetch restarts at RESET_PC.
